// File: rtl/axi_pkg.sv
// Shared response codes and FSM state types for the AXI slave memory.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 subset (INCR, full-width beats) carried between master and axi_slave_mem.
interface axi_slave_mem_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_slave_regfile.sv
// Flop-array word memory: byte-strobed synchronous write, combinational read, async clear.
module axi_slave_regfile #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [MEM_AW-1:0]   waddr_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [MEM_AW-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [2**MEM_AW-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave over a local word memory; independent write and read engines,
// one transaction outstanding each, SLVERR for beats outside the address window.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter              S_AXI_BASE_ADDR  = 32'h4000_0000,
    parameter int          S_AXI_ID_WIDTH   = 1,
    parameter int          S_AXI_ADDR_WIDTH = 32,
    parameter int          S_AXI_DATA_WIDTH = 32,
    parameter int          S_AXI_MEM_AW     = 6
) (
    input  logic           s_axi_aclk,
    input  logic           s_axi_aresetn,
    axi_slave_mem_if.slave s_axi
);

    localparam int BW  = S_AXI_DATA_WIDTH / 8;
    localparam int SH  = $clog2(BW);
    localparam int AXW = S_AXI_ADDR_WIDTH + 1;
    localparam logic [AXW-1:0] BASE    = AXW'(S_AXI_BASE_ADDR);
    localparam logic [AXW-1:0] DEPTH_W = AXW'(2**S_AXI_MEM_AW);
    localparam logic [AXW-1:0] STEP    = AXW'(BW);

    // Addresses carry one extra bit so a burst running off the top never wraps into the window.
    function automatic logic [AXW-1:0] align(input logic [S_AXI_ADDR_WIDTH-1:0] a);
        return {1'b0, a} & ~AXW'(BW - 1);
    endfunction

    function automatic logic in_win(input logic [AXW-1:0] a);
        logic [AXW-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> SH) < DEPTH_W);
    endfunction

    function automatic logic [S_AXI_MEM_AW-1:0] widx(input logic [AXW-1:0] a);
        return S_AXI_MEM_AW'((a - BASE) >> SH);
    endfunction

    // ---------------- write engine ----------------
    wstate_e                   w_state_q;
    logic                      awready_q, wready_q, bvalid_q, werr_q;
    logic [1:0]                bresp_q;
    logic [S_AXI_ID_WIDTH-1:0] bid_q;
    logic [AXW-1:0]            waddr_q;
    logic [7:0]                wlen_q, wcnt_q;
    logic                      w_fire, w_last_beat, w_inwin, w_beat_err, mem_we_d;

    assign w_fire      = wready_q && s_axi.wvalid;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_inwin     = in_win(waddr_q);
    assign w_beat_err  = !w_inwin || (s_axi.wlast != w_last_beat);
    assign mem_we_d    = w_fire && w_inwin;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && s_axi.awvalid) begin
                        bid_q     <= s_axi.awid;
                        waddr_q   <= align(s_axi.awaddr);
                        wlen_q    <= s_axi.awlen;
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    // The beat count closes the burst; wlast only feeds the error flag.
                    if (w_fire) begin
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            wcnt_q  <= wcnt_q + 8'd1;
                            waddr_q <= waddr_q + STEP;
                            werr_q  <= werr_q || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rstate_e                     r_state_q;
    logic                        arready_q, rvalid_q, rlast_q, rd_inwin;
    logic [1:0]                  rresp_q;
    logic [S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [S_AXI_DATA_WIDTH-1:0] rdata_q, mem_rdata;
    logic [AXW-1:0]              raddr_q, rd_addr_d;
    logic [7:0]                  rlen_q, rcnt_q;

    // raddr_q already points at the next beat, so one read port serves both first and later beats.
    assign rd_addr_d = (r_state_q == R_IDLE) ? align(s_axi.araddr) : raddr_q;
    assign rd_inwin  = in_win(rd_addr_d);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && s_axi.arvalid) begin
                        arready_q <= 1'b0;
                        rid_q     <= s_axi.arid;
                        rlen_q    <= s_axi.arlen;
                        rcnt_q    <= '0;
                        raddr_q   <= rd_addr_d + STEP;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_inwin ? mem_rdata : '0;
                        rresp_q   <= rd_inwin ? RESP_OKAY : RESP_SLVERR;
                        rlast_q   <= (s_axi.arlen == 8'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && s_axi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 8'd1;
                            raddr_q <= raddr_q + STEP;
                            rdata_q <= rd_inwin ? mem_rdata : '0;
                            rresp_q <= rd_inwin ? RESP_OKAY : RESP_SLVERR;
                            rlast_q <= (rcnt_q + 8'd1 == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axi_slave_regfile #(
        .DATA_W (S_AXI_DATA_WIDTH),
        .MEM_AW (S_AXI_MEM_AW)
    ) u_regfile (
        .clk_i   (s_axi_aclk),
        .rst_ni  (s_axi_aresetn),
        .we_i    (mem_we_d),
        .waddr_i (widx(waddr_q)),
        .wstrb_i (s_axi.wstrb),
        .wdata_i (s_axi.wdata),
        .raddr_i (widx(rd_addr_d)),
        .rdata_o (mem_rdata)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rvalid  = rvalid_q;

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
AXI4 memory-mapped slave that terminates bursts from the team's AXI master into a local flop-array memory of 2^S_AXI_MEM_AW data words, for bring-up and master verification. It has independent write and read engines, each with one transaction outstanding. INCR bursts only; every beat is full width.

Parameters:
S_AXI_BASE_ADDR, 32'h4000_0000, byte address of memory word 0
S_AXI_ID_WIDTH, 1, width of awid/bid/arid/rid
S_AXI_ADDR_WIDTH, 32, byte address width
S_AXI_DATA_WIDTH, 32, data width; must be 32 or 64
S_AXI_MEM_AW, 6, log2 of memory depth in words (default 64 words = 256 B window)

Ports:
s_axi_aclk  in  1  clock; all logic on rising edge
s_axi_aresetn  in  1  reset; one clock; asynchronous, active-low
s_axi_awid  in  ID_WIDTH  write transaction ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address; low log2(DATA_WIDTH/8) bits ignored
s_axi_awlen  in  8  beats minus 1
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat marker
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  echo of latched awid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read transaction ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address; low bits ignored
s_axi_arlen  in  8  beats minus 1
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echo of latched arid
s_axi_rdata  out  DATA_WIDTH  read data, registered
s_axi_rresp  out  2  per-beat response, 00 or 10
s_axi_rlast  out  1  final read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: all outputs 0 and memory cleared to 0. Both FSMs return to IDLE immediately, including mid-burst, and the burst is abandoned. awready/arready rise on the first edge after deassertion.
- Word index = (addr - BASE) >> log2(DATA_WIDTH/8), computed at ADDR_WIDTH+1 bits with no wrap. A beat is in-window iff addr >= BASE and index < 2^MEM_AW. The index increments by 1 per accepted beat (INCR).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id, index and len; clear the beat counter and error flag; awready=0, wready=1 next cycle.
  - W_DATA: each wvalid&&wready writes in-window beats byte-wise per wstrb. An out-of-window beat is dropped and sets the error flag.
  - Beat count, not wlast, ends the burst. wlast=1 before beat len, or wlast=0 on beat len, sets the error flag.
  - After beat len: wready=0, bvalid=1, bresp = error ? 10 : 00, bid = latched id.
  - W_RESP: hold bvalid until bready, then W_IDLE (awready=1 the cycle after the B handshake).
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, arready=0; next cycle rvalid=1 with rdata = mem[index] (0 if out of window), rresp per beat, rlast = (len==0).
  - R_DATA: on rvalid&&rready, load the next beat's data/resp/rlast in the same edge (full throughput, no bubbles). rdata/rresp/rlast/rid hold stable while rvalid&&!rready. After the last beat: rvalid=0, then R_IDLE.
- Write and read in the same cycle on the same word: the read returns the pre-write value, because rdata is loaded from the old memory contents.
- A burst crossing the window end completes with the full beat count: in-window beats behave normally, later beats get SLVERR (reads return 0).
- Read and write engines are fully independent. There is no ordering between them.

Decomposition:
- Package axi_pkg: RESP_OKAY/RESP_SLVERR constants and the write/read FSM state typedefs.
- Sub-module axi_slave_regfile: 2^MEM_AW x DATA_WIDTH flop array with synchronous byte-strobe write, combinational read and async clear.

Test Plan:
- Write: awaddr 0x4000_0010, awlen 3, data 0x11..0x44, wstrb F -> bresp 00, bid echoed. Read back arlen 3 -> 0x11,0x22,0x33,0x44; rlast on beat 4 only.
- Strobes: word 0 preset 0xAABBCCDD, write 0x11223344 with wstrb 0101 -> read 0xAA22CC44.
- Window boundary: awaddr 0x4000_00F8, awlen 3 -> words 62 and 63 written, bresp 10. Read same range -> beats 3-4 return 0 with rresp 10.
- Backpressure: rready toggled 1010..., bready held 0 for 5 cycles -> R/B outputs stable while stalled, no beat lost or duplicated, awready=0 until the B handshake.
- wlast error and reset: write awlen 1 with wlast on beat 0 -> 2 beats accepted, bresp 10. Then assert aresetn=0 mid read burst -> rvalid=0 the same cycle, memory 0, arready=1 after release.
